// File: rtl/multiple_sequence_generator_if.sv
// Handshake and control bundle for the multiple sequence generator.
// master: the generator side; slave: the requester/consumer side.
interface multiple_sequence_generator_if #(
  parameter int unsigned NUM_W = 5
);
  logic             start;
  logic [2:0]       sel;
  logic [NUM_W-1:0] number;
  logic             valid;
  logic             ready;
  logic             last;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] count;

  modport master (
    input  start, sel, ready,
    output number, valid, last, busy, done, count
  );

  modport slave (
    output start, sel, ready,
    input  number, valid, last, busy, done, count
  );
endinterface

// File: rtl/multiple_sequence_generator.sv
// Multiple sequence generator: emits every multiple of (sel+2) that fits in
// NUM_W bits, in ascending order, one value per valid/ready handshake.
// Reports the handshake count of the run and pulses done when it completes.
module multiple_sequence_generator #(
  parameter int unsigned NUM_W         = 5,
  parameter bit          START_AT_ZERO = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  multiple_sequence_generator_if.master bus
);

  // Arithmetic width: one bit above the larger of the number width and the
  // 4-bit divisor, so number + divisor can never wrap silently.
  localparam int unsigned AW = ((NUM_W > 4) ? NUM_W : 4) + 1;
  localparam logic [AW-1:0] MAXV = {{(AW-NUM_W){1'b0}}, {NUM_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [NUM_W-1:0] number_q, number_d;
  logic [NUM_W-1:0] count_q, count_d;
  logic [3:0]       divisor_q, divisor_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]    sel_div;
  logic [AW-1:0] sel_div_ext;
  logic [AW-1:0] div_ext;
  logic [AW-1:0] first;
  logic [AW-1:0] first_sum;
  logic [AW-1:0] sum;
  logic [AW-1:0] sum_next;

  assign sel_div     = {1'b0, bus.sel} + 4'd2;
  assign sel_div_ext = {{(AW-4){1'b0}}, sel_div};
  assign div_ext     = {{(AW-4){1'b0}}, divisor_q};
  assign first       = START_AT_ZERO ? '0 : sel_div_ext;
  assign first_sum   = first + sel_div_ext;
  assign sum         = {{(AW-NUM_W){1'b0}}, number_q} + div_ext;
  // Only consumed while last_q=0, i.e. sum <= MAXV, so this cannot overflow AW.
  assign sum_next    = sum + div_ext;

  // Next-state and next-output logic; every register defaults to holding.
  always_comb begin
    state_d   = state_q;
    number_d  = number_q;
    count_d   = count_q;
    divisor_d = divisor_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          divisor_d = sel_div;
          count_d   = '0;
          if (!START_AT_ZERO && (first > MAXV)) begin
            number_d = '0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            number_d = first[NUM_W-1:0];
            valid_d  = 1'b1;
            last_d   = (first_sum > MAXV);
            state_d  = EMIT;
          end
        end
      end
      EMIT: begin
        if (valid_q && bus.ready) begin
          count_d = count_q + 1'b1;
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            number_d = sum[NUM_W-1:0];
            last_d   = (sum_next > MAXV);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      number_q  <= '0;
      count_q   <= '0;
      divisor_q <= 4'd2;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      number_q  <= number_d;
      count_q   <= count_d;
      divisor_q <= divisor_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.number = number_q;
  assign bus.count  = count_q;
  assign bus.valid  = valid_q;
  assign bus.last   = last_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: doc/multiple_sequence_generator.md
Name: multiple_sequence_generator

Overview:
- Source side of the Smart Math Tutor number path: given a divisor selector, emits every multiple of (sel+2) in the NUM_W-bit range, in ascending order.
- One value per valid/ready handshake, so the multiple-check logic, a display, or a scoreboard can consume the sequence at its own rate.
- Reports per-run count and completion.
- The selector encoding is the team's existing 3-bit code: divisor = sel + 2, covering 2..9.

Parameters:
- NUM_W, 5: width of emitted numbers; sequence range is 0 .. 2^NUM_W-1.
- START_AT_ZERO, 1: 1 = first emitted value is 0; 0 = first emitted value is the divisor.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new run; sampled only in IDLE.
- sel  input  3  divisor selector, divisor = sel+2; captured when start is accepted.
- number  output  NUM_W  current multiple, valid while valid=1.
- valid  output  1  number is presented.
- ready  input  1  consumer accepts number when valid&ready at a rising edge.
- last  output  1  high with valid on the final multiple of the run.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after the final handshake.
- count  output  NUM_W  handshakes completed in the current or most recent run.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE immediately.
  - number=0, valid=0, last=0, busy=0, done=0, count=0, latched divisor=2.
  - A reset mid-run aborts the run with no done pulse.
- All outputs are registered.
- Internal arithmetic is NUM_W+1 bits: nxt = number + divisor. No wrap-around is ever emitted.
- States are IDLE, EMIT and DONE.
- IDLE:
  - start=1 at an edge: latch divisor = sel+2 and clear count to 0.
  - Load number = 0 if START_AT_ZERO, else divisor; set valid=1 and busy=1; go to EMIT. valid is high in the cycle after start is sampled.
  - If START_AT_ZERO=0 and divisor > 2^NUM_W-1 (only possible for small NUM_W), go straight to DONE with count=0.
- EMIT:
  - last is registered as (number + divisor > 2^NUM_W-1) and is updated together with number.
  - valid&ready with last=0: number <= number + divisor and count <= count+1; valid stays 1 (back-to-back, one value per cycle).
  - valid&ready with last=1: count <= count+1, valid <= 0, last <= 0; go to DONE.
  - valid&!ready: number, last and count hold stable; valid stays high. Valid is never withdrawn before acceptance.
- DONE: done=1 for exactly one cycle and busy stays 1; then return to IDLE. number holds its final value and count holds its total until the next accepted start.
- start while busy is ignored, with no effect on the run. sel changes during a run are ignored.
- Expected run totals, NUM_W=5, START_AT_ZERO=1:

| sel | divisor | count | range |
|---|---|---|---|
| 0 | 2 | 16 | 0..30 |
| 1 | 3 | 11 | 0..30 |
| 2 | 4 | 8 | 0..28 |
| 3 | 5 | 7 | 0..30 |
| 4 | 6 | 6 | 0..30 |
| 5 | 7 | 5 | 0..28 |
| 6 | 8 | 4 | 0..24 |
| 7 | 9 | 4 | 0..27 |

- Every emitted number, fed to the multiple checker with the same sel, must yield ismultiple=1.

Test Plan:
- Reset values: hold rst_n=0, then release -> all outputs 0 and state IDLE; assert rst_n low asynchronously mid-cycle during EMIT -> valid, busy and last drop without waiting for a clock edge, and no done pulse.
- sel=3, start 1 cycle, ready tied 1 -> valid from the next cycle, numbers 0,5,10,15,20,25,30 on consecutive cycles, last only with 30, done pulse one cycle later, count=7.
- sel=7, ready toggling 1,0,0,1,... -> values 0,9,18,27 each held stable while ready=0, last with 27, count=4, no value skipped or repeated.
- Sweep sel=0..7, ready=1 -> counts 16,11,8,7,6,5,4,4; each value checked against the multiple checker's ismultiple=1; max value 30,30,28,30,30,28,24,27.
- start pulsed and sel changed during a sel=0 run -> run continues with divisor 2 through 30, count=16, and no second run starts.
- START_AT_ZERO=0, sel=6 -> values 8,16,24 with last on 24, count=3; a start held high through DONE begins a new run only after the return to IDLE.
